// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared decode types for the execute stage:
//   alu_op_t    - operation select of the core's single-cycle ALU
//   mdu_op_t    - RV32M operation select (encoding follows funct3)
//   mdu_state_t - state encoding of the iterative multiply/divide sequencer
//   MDU_ITER    - number of shift/add (or shift/subtract) iterations
// Small decode helpers for mdu_op_t live here so every user agrees on them.
// -----------------------------------------------------------------------------
package decoder_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_SRA  = 4'd6,
        ALU_OR   = 4'd7,
        ALU_AND  = 4'd8
    } alu_op_t;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_t;

    // Iteration count; the 5-bit step counter runs 0 .. MDU_ITER-1.
    localparam int unsigned MDU_ITER     = 32;
    localparam logic [4:0]  MDU_CNT_LAST = 5'(MDU_ITER - 1);

    function automatic logic mdu_is_div(input mdu_op_t op);
        return op[2];
    endfunction

    function automatic logic mdu_is_rem(input mdu_op_t op);
        return op[2] & op[1];
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic mdu_rs1_signed(input mdu_op_t op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM.
    function automatic logic mdu_rs2_signed(input mdu_op_t op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// -----------------------------------------------------------------------------
// mdu_sign_fix
// Combinational conditional two's-complement of a 32-bit word.
//   value_i : input word
//   neg_i   : 1 = output ~value_i + cin_i, 0 = pass value_i through
//   cin_i   : increment applied when negating (1 for a plain negate/abs;
//             the borrow from the low word when negating the high half of
//             a 64-bit product)
//   value_o : result
// -----------------------------------------------------------------------------
module mdu_sign_fix (
    input  logic [31:0] value_i,
    input  logic        neg_i,
    input  logic        cin_i,
    output logic [31:0] value_o
);

    // Invert-and-increment when negation is requested.
    always_comb begin
        if (neg_i) begin
            value_o = ~value_i + {31'd0, cin_i};
        end else begin
            value_o = value_i;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq
// Iterative RV32M multiply/divide sequencer. Borrows the core's shared
// single-cycle ALU for its per-bit add/subtract while in CALC (alu_own=1).
//   clk, reset     : rising-edge clock, asynchronous active-low reset
//   start, kill    : request (sampled in IDLE only) / synchronous abort
//   op, rs1, rs2   : operation and operands, latched on the accepted start
//   busy, done     : not-IDLE flag / one-cycle completion pulse
//   result         : final value, held until the next done
//   alu_own        : ALU inputs are driven by this block
//   alu_a, alu_b, alu_sub_arith, alu_op : ALU drive
//   alu_res        : ALU result, consumed in the same cycle
// Optional feature: define MDU_EARLY_OUT_EN to skip CALC for divide by zero,
// signed divide overflow, and multiplies with a zero operand.
// -----------------------------------------------------------------------------
module mdu_seq
    import decoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        kill,
    input  mdu_op_t     op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_own,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_sub_arith,
    output alu_op_t     alu_op,
    input  logic [31:0] alu_res
);

    mdu_state_t  state_q, state_d;
    mdu_op_t     op_q, op_d;
    logic [31:0] acc_hi_q, acc_hi_d;   // product high word / partial remainder
    logic [31:0] acc_lo_q, acc_lo_d;   // multiplier->product low / dividend->quotient
    logic [31:0] mcand_q, mcand_d;     // multiplicand / divisor (absolute value)
    logic [31:0] rs1_q, rs1_d;         // raw rs1, returned as remainder on divide by zero
    logic        neg_q, neg_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic        rs1_neg_s, rs2_neg_s;
    logic [31:0] rs1_abs_s, rs2_abs_s;
    logic        ovf_start_s, early_s;
    logic [31:0] rem_shift_s;
    logic [31:0] fix_word_s, fix_neg_s, fix_result_s;
    logic        fix_cin_s;
    logic        carry_s, borrow_s, take_s;

    assign rs1_neg_s   = mdu_rs1_signed(op) & rs1[31];
    assign rs2_neg_s   = mdu_rs2_signed(op) & rs2[31];
    assign ovf_start_s = ((op == MDU_DIV) || (op == MDU_REM)) &&
                         (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

`ifdef MDU_EARLY_OUT_EN
    assign early_s = mdu_is_div(op) ? ((rs2 == 32'd0) || ovf_start_s)
                                    : ((rs1 == 32'd0) || (rs2 == 32'd0));
`else
    assign early_s = 1'b0;
`endif

    mdu_sign_fix u_abs_rs1 (.value_i(rs1), .neg_i(rs1_neg_s), .cin_i(1'b1), .value_o(rs1_abs_s));
    mdu_sign_fix u_abs_rs2 (.value_i(rs2), .neg_i(rs2_neg_s), .cin_i(1'b1), .value_o(rs2_abs_s));

    // Shifted partial remainder R' (low 32 bits); R[31] is the 33rd bit.
    assign rem_shift_s = {acc_hi_q[30:0], acc_lo_q[31]};

    // Select the word to return and its negate carry-in.
    always_comb begin
        if (mdu_is_div(op_q)) begin
            fix_word_s = mdu_is_rem(op_q) ? acc_hi_q : acc_lo_q;
            fix_cin_s  = 1'b1;
        end else if (op_q == MDU_MUL) begin
            fix_word_s = acc_lo_q;
            fix_cin_s  = 1'b1;
        end else begin
            // High half of a negated 64-bit product: the +1 only ripples
            // into the high word when the low word is zero.
            fix_word_s = acc_hi_q;
            fix_cin_s  = (acc_lo_q == 32'd0);
        end
    end

    mdu_sign_fix u_fix (.value_i(fix_word_s), .neg_i(neg_q), .cin_i(fix_cin_s), .value_o(fix_neg_s));

    // RISC-V divide-by-zero and signed-overflow results override the datapath.
    always_comb begin
        if (mdu_is_div(op_q) && dz_q) begin
            fix_result_s = mdu_is_rem(op_q) ? rs1_q : 32'hFFFF_FFFF;
        end else if (ovf_q) begin
            fix_result_s = mdu_is_rem(op_q) ? 32'd0 : 32'h8000_0000;
        end else begin
            fix_result_s = fix_neg_s;
        end
    end

    // ALU drive: iteration operands in CALC, idle values otherwise.
    always_comb begin
        alu_a         = 32'd0;
        alu_b         = 32'd0;
        alu_sub_arith = 1'b0;
        alu_op        = ALU_ADD;
        if (state_q == MDU_CALC) begin
            if (mdu_is_div(op_q)) begin
                alu_a         = rem_shift_s;
                alu_b         = mcand_q;
                alu_sub_arith = 1'b1;
            end else begin
                // A zero multiplier bit still adds, just with b = 0.
                alu_a = acc_hi_q;
                alu_b = acc_lo_q[0] ? mcand_q : 32'd0;
            end
        end else begin
            alu_a         = 32'd0;
            alu_b         = 32'd0;
            alu_sub_arith = 1'b0;
        end
    end

    assign carry_s  = (alu_res < alu_b);
    assign borrow_s = (alu_res > alu_a);
    assign take_s   = acc_hi_q[31] | ~borrow_s;

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        rs1_d    = rs1_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (kill) begin
            state_d = MDU_IDLE;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (start) begin
                        op_d     = op;
                        acc_hi_d = 32'd0;
                        mcand_d  = mdu_is_div(op) ? rs2_abs_s : rs1_abs_s;
                        acc_lo_d = mdu_is_div(op) ? rs1_abs_s : rs2_abs_s;
                        rs1_d    = rs1;
                        // The remainder follows rs1; everything else uses the xor.
                        neg_d    = mdu_is_rem(op) ? rs1_neg_s : (rs1_neg_s ^ rs2_neg_s);
                        dz_d     = (rs2 == 32'd0);
                        ovf_d    = ovf_start_s;
                        cnt_d    = 5'd0;
                        if (early_s) begin
                            state_d = MDU_FIX;
                            // Zero product when a multiply skips CALC.
                            if (!mdu_is_div(op)) begin
                                acc_lo_d = 32'd0;
                            end else begin
                                acc_lo_d = rs1_abs_s;
                            end
                        end else begin
                            state_d = MDU_CALC;
                        end
                    end else begin
                        state_d = MDU_IDLE;
                    end
                end
                MDU_CALC: begin
                    if (mdu_is_div(op_q)) begin
                        acc_hi_d = take_s ? alu_res : rem_shift_s;
                        acc_lo_d = {acc_lo_q[30:0], take_s};
                    end else begin
                        acc_hi_d = {carry_s, alu_res[31:1]};
                        acc_lo_d = {alu_res[0], acc_lo_q[31:1]};
                    end
                    cnt_d   = cnt_q + 5'd1;
                    state_d = (cnt_q == MDU_CNT_LAST) ? MDU_FIX : MDU_CALC;
                end
                MDU_FIX: begin
                    result_d = fix_result_s;
                    state_d  = MDU_DONE;
                end
                MDU_DONE: begin
                    state_d = MDU_IDLE;
                end
                default: begin
                    state_d = MDU_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MDU_IDLE;
            op_q     <= MDU_MUL;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            mcand_q  <= 32'd0;
            rs1_q    <= 32'd0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            rs1_q    <= rs1_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy    = (state_q != MDU_IDLE);
    assign done    = (state_q == MDU_DONE);
    assign alu_own = (state_q == MDU_CALC);
    assign result  = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// -----------------------------------------------------------------------------
// tb_mdu_seq
// Bench for mdu_seq. A reference model computes each RV32M result with plain
// 64-bit/integer arithmetic and tracks, per accepted request, the cycle
// window in which busy/alu_own/done must be high; a negedge compare process
// checks the DUT against it every cycle. Directed cases pin the model with
// hand-computed literals; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mdu_seq;
    import decoder_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        kill;
    mdu_op_t     op;
    logic [31:0] rs1, rs2;
    logic        busy, done, alu_own, alu_sub_arith;
    logic [31:0] result, alu_a, alu_b, alu_res;
    alu_op_t     alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_seq dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .op(op),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result),
        .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sub_arith(alu_sub_arith), .alu_op(alu_op), .alu_res(alu_res)
    );

    // The core's shared ALU: add, or subtract when alu_sub_arith is set.
    assign alu_res = alu_sub_arith ? (alu_a - alu_b) : (alu_a + alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, expv, $time);
        end
    endtask

    function automatic bit is_div_op(input mdu_op_t o);
        return (o == MDU_DIV) || (o == MDU_DIVU) || (o == MDU_REM) || (o == MDU_REMU);
    endfunction

    // RV32M result from the ISA definition.
    function automatic logic [31:0] model_res(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            MDU_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            MDU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            MDU_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            MDU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            MDU_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            MDU_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            MDU_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            MDU_REMU: return (b == 32'd0) ? a : a % b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic bit model_early(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        if (is_div_op(o))
            return (b == 32'd0) ||
                   ((o == MDU_DIV || o == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 32'd0) || (b == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Model state: one request in flight, accepted at edge count ks.
    bit          act;
    int          e, ks, m_lat;
    bit          m_early;
    mdu_op_t     m_op;
    logic [31:0] m_res, last_res;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            act      <= 1'b0;
            e        <= 0;
            ks       <= 0;
            m_lat    <= 34;
            m_early  <= 1'b0;
            m_op     <= MDU_MUL;
            m_res    <= 32'd0;
            last_res <= 32'd0;
        end else begin
            e <= e + 1;
            if (act) begin
                if (kill) begin
                    act <= 1'b0;
                end else begin
                    if (e - ks == m_lat - 2) last_res <= m_res;
                    if (e - ks == m_lat - 1) act <= 1'b0;
                end
            end else if (start && !kill) begin
                act     <= 1'b1;
                ks      <= e + 1;
                m_op    <= op;
                m_res   <= model_res(op, rs1, rs2);
                m_early <= model_early(op, rs1, rs2);
                m_lat   <= model_early(op, rs1, rs2) ? 2 : 34;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int n;
        bit own_e, done_e;
        n      = e - ks;
        own_e  = act && !m_early && (n < 32);
        done_e = act && (n == m_lat - 1);
        check("busy",    32'(busy),    32'(act));
        check("done",    32'(done),    32'(done_e));
        check("alu_own", 32'(alu_own), 32'(own_e));
        check("result",  result,       last_res);
        check("alu_op",  32'(alu_op),  32'(ALU_ADD));
        check("alu_sub", 32'(alu_sub_arith), 32'(own_e && is_div_op(m_op)));
        if (!own_e) begin
            check("alu_a_idle", alu_a, 32'd0);
            check("alu_b_idle", alu_b, 32'd0);
        end
    end

    task automatic wait_idle();
        int g;
        g = 0;
        while (act && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (act) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", g);
        end
    endtask

    // Issue one request and check result, latency and ALU-ownership length.
    task automatic directed(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expv, input string name);
        int lat, own;
        bit early;
        check({name, "_model"}, model_res(o, a, b), expv);
        early = model_early(o, a, b);
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        lat = 0; own = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (alu_own) own++;
        end while (!done && lat < 100);
        check({name, "_result"}, result, expv);
        check({name, "_latency"}, 32'(lat), early ? 32'd2 : 32'd34);
        check({name, "_own_cycles"}, 32'(own), early ? 32'd0 : 32'd32);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int g;
        reset = 1'b0; start = 1'b0; kill = 1'b0;
        op = MDU_MUL; rs1 = 32'd0; rs2 = 32'd0;
        #2;
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_result",  result,       32'd0);
        check("rst_alu_own", 32'(alu_own), 32'd0);
        check("rst_alu_a",   alu_a,        32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        directed(MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7");
        directed(MDU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min");
        directed(MDU_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulhu_min");
        directed(MDU_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, "mulhsu_m1");
        directed(MDU_DIVU,   32'd100,        32'd7,         32'd14,        "divu_100_7");
        directed(MDU_REMU,   32'd100,        32'd7,         32'd2,         "remu_100_7");
        directed(MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2");
        directed(MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2");
        directed(MDU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, "div_by0");
        directed(MDU_REM,    32'd5,          32'd0,         32'd5,         "rem_by0");
        directed(MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        directed(MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf");
        directed(MDU_MUL,    32'd0,          32'h1234_5678, 32'd0,         "mul_zero");

        // kill at cycle k+10 together with a new start
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = MDU_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (!(act && (e - ks == 9)) && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("kill_reach_k10", 32'(g < 100), 32'd1);
        kill = 1'b1; start = 1'b1; op = MDU_MUL; rs1 = 32'd3; rs2 = 32'd5;
        @(negedge clk);
        kill = 1'b0; start = 1'b0;
        check("kill_busy", 32'(busy), 32'd0);
        check("kill_done", 32'(done), 32'd0);
        check("kill_result", result, 32'd0);
        directed(MDU_MUL, 32'd3, 32'd5, 32'd15, "after_kill");

        // asynchronous reset in the middle of an operation
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = MDU_MUL; rs1 = 32'd123; rs2 = 32'd456;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (!(act && (e - ks == 19)) && g < 100) begin
            @(negedge clk);
            g++;
        end
        #2 reset = 1'b0;
        #1;
        check("arst_busy",    32'(busy),    32'd0);
        check("arst_done",    32'(done),    32'd0);
        check("arst_result",  result,       32'd0);
        check("arst_alu_own", 32'(alu_own), 32'd0);
        check("arst_alu_a",   alu_a,        32'd0);
        check("arst_alu_b",   alu_b,        32'd0);
        check("arst_alu_sub", 32'(alu_sub_arith), 32'd0);
        check("arst_alu_op",  32'(alu_op),  32'(ALU_ADD));
        @(negedge clk);
        reset = 1'b1;
        directed(MDU_REMU, 32'd100, 32'd7, 32'd2, "after_reset");

        // randomized traffic: starts while busy, back-to-back, occasional kills
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            kill  = ($urandom_range(0, 79) == 0);
            op    = mdu_op_t'(3'($urandom_range(0, 7)));
            rs1   = rand_opnd();
            rs2   = rand_opnd();
        end
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        wait_idle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
